// File: rtl/ldpc_pkg.sv
// rtl/ldpc_pkg.sv - shared LDPC decoder types, defaults and sign-magnitude helpers
package ldpc_pkg;

    localparam int DATA_WIDTH = 6;
    localparam int MAX_DEG    = 8;
    localparam int IDX_W      = $clog2(MAX_DEG);

    typedef struct packed {
        logic                  sign;
        logic [DATA_WIDTH-1:0] mag;
    } sm_msg_t;

    function automatic logic sm_sign(input sm_msg_t m);
        return m.sign;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sm_mag(input sm_msg_t m);
        return m.mag;
    endfunction

    typedef enum logic {ACC, EMIT} cnu_state_t;

endpackage

// File: rtl/min2_tracker.sv
// rtl/min2_tracker.sv - next (min1, min2, min1_idx) for one incoming magnitude
module min2_tracker
    import ldpc_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int IW = IDX_W
) (
    input  logic [DW-1:0] min1,
    input  logic [DW-1:0] min2,
    input  logic [IW-1:0] min1_idx,
    input  logic [DW-1:0] mag,
    input  logic [IW-1:0] cnt,
    output logic [DW-1:0] min1_nxt,
    output logic [DW-1:0] min2_nxt,
    output logic [IW-1:0] min1_idx_nxt
);

    // Strict compares: on a tie the earlier edge keeps min1.
    always_comb begin
        min1_nxt     = min1;
        min2_nxt     = min2;
        min1_idx_nxt = min1_idx;
        if (mag < min1) begin
            min2_nxt     = min1;
            min1_nxt     = mag;
            min1_idx_nxt = cnt;
        end else if (mag < min2) begin
            min2_nxt = mag;
        end
    end

endmodule

// File: rtl/cnu_minsum_serial.sv
// rtl/cnu_minsum_serial.sv - serial min-sum check-node unit (optional CNU_OFFSET_EN offset min-sum)
module cnu_minsum_serial
    import ldpc_pkg::*;
#(
    parameter int DATA_WIDTH = ldpc_pkg::DATA_WIDTH,
    parameter int MAX_DEG    = ldpc_pkg::MAX_DEG,
    parameter int OFFSET     = 1,
    parameter int IDX_W      = $clog2(MAX_DEG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH:0]   in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   out_data,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_last,
    output logic                  busy
);

    localparam logic [IDX_W-1:0]      LAST_CNT = IDX_W'(MAX_DEG - 1);
    localparam logic [DATA_WIDTH-1:0] OFF_M    = DATA_WIDTH'(OFFSET);

    cnu_state_t             state, state_nxt;
    logic [IDX_W-1:0]       cnt, k, last_idx, min1_idx;
    logic [DATA_WIDTH-1:0]  min1, min2;
    logic                   sgn_acc;
    logic [MAX_DEG-1:0]     sign_buf;

    logic [DATA_WIDTH-1:0]  min1_nxt, min2_nxt;
    logic [IDX_W-1:0]       min1_idx_nxt;
    logic                   in_fire, out_fire, row_end, emit_done;
    logic [DATA_WIDTH-1:0]  raw_mag, adj_mag;
    logic                   emit_sign;

    min2_tracker #(.DW(DATA_WIDTH), .IW(IDX_W)) u_min2_tracker (
        .min1         (min1),
        .min2         (min2),
        .min1_idx     (min1_idx),
        .mag          (in_data[DATA_WIDTH-1:0]),
        .cnt          (cnt),
        .min1_nxt     (min1_nxt),
        .min2_nxt     (min2_nxt),
        .min1_idx_nxt (min1_idx_nxt)
    );

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign row_end   = in_fire & (in_last | (cnt == LAST_CNT));
    assign emit_done = out_fire & (k == last_idx);

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (row_end)   state_nxt = EMIT;
            EMIT:    if (emit_done) state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    always_comb begin
        raw_mag = (k == min1_idx) ? min2 : min1;
`ifdef CNU_OFFSET_EN
        adj_mag = (raw_mag > OFF_M) ? raw_mag - OFF_M : '0;
`else
        adj_mag = raw_mag;
`endif
        // Zero magnitude is always emitted as +0.
        emit_sign = (adj_mag != '0) & (sgn_acc ^ sign_buf[k]);
    end

`ifndef CNU_OFFSET_EN
    logic unused_offset;
    assign unused_offset = ^OFF_M;
`endif

    always_comb begin
        in_ready  = (state == ACC);
        busy      = (state == EMIT);
        out_valid = busy;
        out_data  = busy ? {emit_sign, adj_mag} : '0;
        out_idx   = busy ? k : '0;
        out_last  = busy & (k == last_idx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ACC;
            cnt      <= '0;
            k        <= '0;
            last_idx <= '0;
            min1     <= '1;
            min2     <= '1;
            min1_idx <= '0;
            sgn_acc  <= 1'b0;
            sign_buf <= '0;
        end else begin
            state <= state_nxt;
            if (in_fire) begin
                sign_buf[cnt] <= in_data[DATA_WIDTH];
                sgn_acc       <= sgn_acc ^ in_data[DATA_WIDTH];
                min1          <= min1_nxt;
                min2          <= min2_nxt;
                min1_idx      <= min1_idx_nxt;
                if (row_end) begin
                    last_idx <= cnt;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (out_fire) begin
                if (emit_done) begin
                    k        <= '0;
                    min1     <= '1;
                    min2     <= '1;
                    min1_idx <= '0;
                    sgn_acc  <= 1'b0;
                    cnt      <= '0;
                end else begin
                    k <= k + 1'b1;
                end
            end
        end
    end

endmodule
